// File: rtl/router_crossbar_pkg.sv
// rtl/router_crossbar_pkg.sv - shared constants and helpers for the router crossbar
package router_crossbar_pkg;

    localparam int LOCAL = 0;
    localparam int EAST  = 1;
    localparam int NORTH = 2;
    localparam int WEST  = 3;
    localparam int SOUTH = 4;

    localparam int V_DEFAULT    = 4;
    localparam int FPAY_DEFAULT = 32;

    typedef enum logic {
        MUX_ONE_HOT = 1'b0,
        MUX_BINARY  = 1'b1
    } mux_kind_e;

    // Flit = 2 header-type bits + one bit per VC + payload.
    function automatic int flit_width(input int v, input int fpay);
        return 2 + v + fpay;
    endfunction

    localparam int FW_DEFAULT = 2 + V_DEFAULT + FPAY_DEFAULT;

    // Ceiling log2, never less than 1 so select vectors keep a legal width.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Lowest set bit wins, so an illegal multi-hot select degrades predictably.
    function automatic int onehot_to_bin(input logic [31:0] onehot, input int n);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (i < n && onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/crossbar_port_mux.sv
// rtl/crossbar_port_mux.sv - P-input flit mux feeding one crossbar output
module crossbar_port_mux
    import router_crossbar_pkg::*;
#(
    parameter int    P        = 5,
    parameter int    FW       = FW_DEFAULT,
    parameter string MUX_TYPE = "ONE_HOT"
) (
    input  logic [P-1:0]    sel,
    input  logic [P*FW-1:0] data_in,
    output logic [FW-1:0]   data_out
);

    generate
        if (MUX_TYPE == "BINARY") begin : g_binary
            localparam int SW = log2(P);
            logic [SW-1:0] idx;

            assign idx      = SW'(onehot_to_bin(32'(sel), P));
            assign data_out = data_in[idx*FW +: FW];
        end else begin : g_one_hot
            // AND-OR mux: an empty select yields all-zero data.
            always_comb begin
                data_out = '0;
                for (int i = 0; i < P; i++) begin
                    data_out = data_out | (data_in[i*FW +: FW] & {FW{sel[i]}});
                end
            end
        end
    endgenerate

endmodule

// File: rtl/router_crossbar.sv
// rtl/router_crossbar.sv - PxP NoC router flit switch with optional output register
module router_crossbar
    import router_crossbar_pkg::*;
#(
    parameter int    V                         = 4,
    parameter int    P                         = 5,
    parameter int    Fpay                      = 32,
    parameter string MUX_TYPE                  = "ONE_HOT",
    parameter int    ADD_PIPREG_AFTER_CROSSBAR = 0,
    parameter string SSA_EN                    = "YES",
    localparam int   FW                        = flit_width(V, Fpay)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [P*(P-1)-1:0]  granted_dest_port_all,
    input  logic [P*FW-1:0]     flit_in_all,
    input  logic [P-1:0]        ssa_flit_wr_all,
    output logic [P*FW-1:0]     flit_out_all,
    output logic [P-1:0]        flit_out_we_all
);

    logic [P-1:0]    sel [P];
    logic [P*FW-1:0] data_comb;
    logic [P-1:0]    we_comb;
    logic            unused_inputs;

    // Grants omit the own-port bit: local bit k skips over index i.
    always_comb begin
        for (int o = 0; o < P; o++) sel[o] = '0;
        for (int i = 0; i < P; i++) begin
            for (int k = 0; k < P - 1; k++) begin
                if (k < i) sel[k][i]   = granted_dest_port_all[i*(P-1) + k];
                else       sel[k+1][i] = granted_dest_port_all[i*(P-1) + k];
            end
        end
    end

    genvar o;
    generate
        for (o = 0; o < P; o++) begin : g_out
            crossbar_port_mux #(
                .P        (P),
                .FW       (FW),
                .MUX_TYPE (MUX_TYPE)
            ) u_mux (
                .sel      (sel[o]),
                .data_in  (flit_in_all),
                .data_out (data_comb[o*FW +: FW])
            );

            assign we_comb[o] = (|sel[o]) | ((SSA_EN == "YES") ? ssa_flit_wr_all[o] : 1'b0);
        end

        if (ADD_PIPREG_AFTER_CROSSBAR != 0) begin : g_pipreg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    flit_out_all    <= '0;
                    flit_out_we_all <= '0;
                end else begin
                    flit_out_all    <= data_comb;
                    flit_out_we_all <= we_comb;
                end
            end
        end else begin : g_comb
            assign flit_out_all    = data_comb;
            assign flit_out_we_all = we_comb;
        end
    endgenerate

    // clk/reset are dead in combinational mode and the strobe is dead with SSA off.
    assign unused_inputs = ^{clk, reset, ssa_flit_wr_all};

endmodule

// File: tb/tb_router_crossbar.sv
// tb/tb_router_crossbar.sv - scoreboard bench for router_crossbar in three configurations
module tb_router_crossbar;

    localparam int P    = 5;
    localparam int V    = 4;
    localparam int FPAY = 32;
    localparam int FW   = 2 + V + FPAY;
    localparam int GW   = P * (P - 1);
    localparam int CW   = P * FW;

    logic          clk;
    logic          reset;
    logic [GW-1:0] granted;
    logic [CW-1:0] flits;
    logic [P-1:0]  ssa;

    logic [CW-1:0] out_a, out_b, out_c;
    logic [P-1:0]  we_a, we_b, we_c;

    router_crossbar #(
        .V(V), .P(P), .Fpay(FPAY), .MUX_TYPE("ONE_HOT"),
        .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("YES")
    ) dut_a (
        .clk(clk), .reset(reset), .granted_dest_port_all(granted),
        .flit_in_all(flits), .ssa_flit_wr_all(ssa),
        .flit_out_all(out_a), .flit_out_we_all(we_a)
    );

    router_crossbar #(
        .V(V), .P(P), .Fpay(FPAY), .MUX_TYPE("BINARY"),
        .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("NO")
    ) dut_b (
        .clk(clk), .reset(reset), .granted_dest_port_all(granted),
        .flit_in_all(flits), .ssa_flit_wr_all(ssa),
        .flit_out_all(out_b), .flit_out_we_all(we_b)
    );

    router_crossbar #(
        .V(V), .P(P), .Fpay(FPAY), .MUX_TYPE("ONE_HOT"),
        .ADD_PIPREG_AFTER_CROSSBAR(1), .SSA_EN("YES")
    ) dut_c (
        .clk(clk), .reset(reset), .granted_dest_port_all(granted),
        .flit_in_all(flits), .ssa_flit_wr_all(ssa),
        .flit_out_all(out_c), .flit_out_we_all(we_c)
    );

    typedef struct {
        logic [CW-1:0] data_oh;
        logic [CW-1:0] data_bin;
        logic [P-1:0]  we_yes;
        logic [P-1:0]  we_no;
        int            cyc;
    } exp_t;

    exp_t q_comb[$];
    exp_t q_pipe[$];
    exp_t mon_e;

    int n_cmp;
    int n_bad;
    int cyc;
    bit mon_en;

    int            tgt [P];
    logic [FW-1:0] fl  [P];
    logic [P-1:0]  ssa_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [FW-1:0] rnd_flit();
        return FW'({$urandom, $urandom});
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < P; i++) begin
            tgt[i] = -1;
            fl[i]  = '0;
        end
        ssa_v = '0;
    endtask

    // Reference model: each input with a target writes its flit to that output.
    task automatic apply(input bit push);
        logic [GW-1:0] g;
        logic [CW-1:0] f;
        exp_t          e;
        int            k;
        g = '0;
        f = '0;
        e.data_oh = '0;
        e.we_yes  = '0;
        e.we_no   = '0;
        for (int o = 0; o < P; o++) e.data_bin[o*FW +: FW] = fl[0];
        for (int i = 0; i < P; i++) begin
            f[i*FW +: FW] = fl[i];
            if (tgt[i] >= 0) begin
                k = (tgt[i] < i) ? tgt[i] : tgt[i] - 1;
                g[i*(P-1) + k]             = 1'b1;
                e.data_oh[tgt[i]*FW +: FW]  = fl[i];
                e.data_bin[tgt[i]*FW +: FW] = fl[i];
                e.we_yes[tgt[i]]            = 1'b1;
                e.we_no[tgt[i]]             = 1'b1;
            end
        end
        e.we_yes = e.we_yes | ssa_v;
        e.cyc    = cyc;
        granted  = g;
        flits    = f;
        ssa      = ssa_v;
        if (push) begin
            q_comb.push_back(e);
            q_pipe.push_back(e);
        end
    endtask

    task automatic step(input bit push);
        @(posedge clk);
        #1;
        apply(push);
    endtask

    // Combinational DUTs answer in the issue cycle, the registered one a cycle later.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q_comb.size() > 0) begin
                mon_e = q_comb.pop_front();
                check("oh_data",  out_a, mon_e.data_oh);
                check("oh_we",    CW'(we_a), CW'(mon_e.we_yes));
                check("bin_data", out_b, mon_e.data_bin);
                check("bin_we",   CW'(we_b), CW'(mon_e.we_no));
            end
            while (q_pipe.size() > 0 && q_pipe[0].cyc < cyc - 1) void'(q_pipe.pop_front());
            if (q_pipe.size() > 0 && q_pipe[0].cyc == cyc - 1) begin
                mon_e = q_pipe.pop_front();
                check("pipe_data", out_c, mon_e.data_oh);
                check("pipe_we",   CW'(we_c), CW'(mon_e.we_yes));
            end
        end
    end

    initial begin
        int perm [P];
        int j, t;
        n_cmp  = 0;
        n_bad  = 0;
        mon_en = 1'b0;
        reset  = 1'b1;
        granted = '0;
        flits   = '0;
        ssa     = '0;
        clear_stim();

        repeat (2) @(posedge clk);
        #1;
        check("reset_data", out_c, '0);
        check("reset_we",   CW'(we_c), '0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Two grants, in0->out3 and in3->out0.
        clear_stim();
        fl[0] = FW'(38'h11); fl[3] = FW'(38'h33);
        fl[1] = rnd_flit(); fl[2] = rnd_flit(); fl[4] = rnd_flit();
        tgt[0] = 3; tgt[3] = 0;
        step(1);

        // Cyclic permutation i -> (i+1)%P.
        clear_stim();
        for (int i = 0; i < P; i++) begin
            fl[i]  = rnd_flit();
            tgt[i] = (i + 1) % P;
        end
        step(1);

        // Static-straight strobe alone.
        clear_stim();
        for (int i = 0; i < P; i++) fl[i] = rnd_flit();
        ssa_v = 5'b00100;
        step(1);

        // Every input to every other output.
        for (int i = 0; i < P; i++) begin
            for (int o = 0; o < P; o++) begin
                if (o != i) begin
                    clear_stim();
                    for (int n = 0; n < P; n++) fl[n] = rnd_flit();
                    tgt[i] = o;
                    step(1);
                end
            end
        end

        // Registered path latency and mid-stream reset, checked directly.
        clear_stim();
        step(0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        q_comb.delete();
        q_pipe.delete();
        clear_stim();
        fl[1] = FW'(38'hABC); tgt[1] = 4;
        apply(0);
        @(posedge clk);
        #1;
        check("pipe_lat_data", CW'(out_c[4*FW +: FW]), CW'(38'hABC));
        check("pipe_lat_we",   CW'(we_c), CW'(5'b10000));
        clear_stim();
        apply(0);
        @(posedge clk);
        #1;
        check("pipe_drop_we", CW'(we_c), '0);
        fl[1] = rnd_flit() | FW'(1); tgt[1] = 4;
        apply(0);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_data", out_c, '0);
        check("async_rst_we",   CW'(we_c), '0);
        @(posedge clk);
        #1;
        check("held_rst_data", out_c, '0);
        clear_stim();
        apply(0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_rst_data", out_c, '0);
            check("post_rst_we",   CW'(we_c), '0);
        end
        mon_en = 1'b1;

        // Random legal matchings with random strobes.
        for (int n = 0; n < 300; n++) begin
            clear_stim();
            for (int i = 0; i < P; i++) perm[i] = i;
            for (int i = P - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < P; i++) begin
                fl[i] = rnd_flit();
                if (perm[i] != i && $urandom_range(0, 3) != 0) tgt[i] = perm[i];
            end
            ssa_v = P'($urandom);
            step(1);
        end

        clear_stim();
        step(1);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (q_comb.size() + q_pipe.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", q_comb.size() + q_pipe.size());
        end
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
